// File: rtl/chip8_tick_tone_if.sv
// ============================================================================
// Module      : chip8_tick_tone_if
// Description : Bundle of run/sound controls and tick/tone outputs exchanged
//               between the timer group and chip8_tick_tone.
//               Optional macro CHIP8_TICK_COUNT_EN adds the 16-bit tick_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chip8_tick_tone_if;
    logic        enable;
    logic        sound_active;
    logic        tick_60;
    logic        tone_out;
    logic        tone_busy;
`ifdef CHIP8_TICK_COUNT_EN
    logic [15:0] tick_count;

    modport master (
        output enable,
        output sound_active,
        input  tick_60,
        input  tone_out,
        input  tone_busy,
        input  tick_count
    );

    modport slave (
        input  enable,
        input  sound_active,
        output tick_60,
        output tone_out,
        output tone_busy,
        output tick_count
    );
`else
    modport master (
        output enable,
        output sound_active,
        input  tick_60,
        input  tone_out,
        input  tone_busy
    );

    modport slave (
        input  enable,
        input  sound_active,
        output tick_60,
        output tone_out,
        output tone_busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/chip8_tick_tone.sv
// ============================================================================
// Module      : chip8_tick_tone
// Description : 60 Hz single-cycle strobe generator plus click-free buzzer
//               square wave driven by the sound timer's active level.
//               Optional macro CHIP8_TICK_COUNT_EN adds a 16-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip8_tick_tone #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 60,
    parameter int unsigned TONE_HZ = 440
) (
    input  wire               clk,
    input  wire               reset,
    chip8_tick_tone_if.slave  bus
);

    localparam int unsigned TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned TONE_HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int unsigned TICK_W    = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int unsigned TONE_W    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // Tick path
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick_60_q;
    logic              tick_60_d;
    logic              w_tick_wrap;

    assign w_tick_wrap = bus.enable && (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_60_d  = 1'b0;
        if (bus.enable) begin
            if (w_tick_wrap) begin
                tick_cnt_d = '0;
                tick_60_d  = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_60_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_60_q  <= tick_60_d;
        end
    end

    assign bus.tick_60 = tick_60_q;

`ifdef CHIP8_TICK_COUNT_EN
    // Advances on the same edge that raises the strobe, so it always equals
    // the number of strobes emitted so far.
    logic [15:0] tick_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_count_q <= '0;
        end else if (w_tick_wrap) begin
            tick_count_q <= tick_count_q + 16'd1;
        end
    end

    assign bus.tick_count = tick_count_q;
`endif

    // ------------------------------------------------------------------
    // Tone path
    // ------------------------------------------------------------------
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [TONE_W-1:0] phase_q;
    logic [TONE_W-1:0] phase_d;
    logic              tone_q;
    logic              tone_d;
    logic              tone_busy_q;
    logic              w_phase_last;
    logic [TONE_W-1:0] w_phase_adv;
    logic              w_tone_adv;

    assign w_phase_last = (phase_q == TONE_LAST);
    assign w_phase_adv  = w_phase_last ? '0 : (phase_q + TONE_W'(1));
    assign w_tone_adv   = w_phase_last ? ~tone_q : tone_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tone_d  = tone_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                tone_d  = 1'b0;
                if (bus.sound_active) begin
                    state_d = S_PLAY;
                    tone_d  = 1'b1;
                end
            end
            S_PLAY: begin
                phase_d = w_phase_adv;
                tone_d  = w_tone_adv;
                if (!bus.sound_active) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.sound_active) begin
                    state_d = S_PLAY;
                    phase_d = w_phase_adv;
                    tone_d  = w_tone_adv;
                end else if (tone_q) begin
                    // Finish the high half so the speaker never sees a runt pulse.
                    phase_d = w_phase_adv;
                    tone_d  = w_tone_adv;
                    if (w_phase_last) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    tone_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                tone_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            tone_q      <= 1'b0;
            tone_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tone_q      <= tone_d;
            tone_busy_q <= (state_d != S_IDLE);
        end
    end

    assign bus.tone_out  = tone_q;
    assign bus.tone_busy = tone_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_chip8_tick_tone.sv
// ============================================================================
// Module      : tb_chip8_tick_tone
// Description : Directed self-checking bench for chip8_tick_tone with
//               CLK_HZ=1200, TICK_HZ=60, TONE_HZ=100 (TICK_DIV=20, TONE_HALF=6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chip8_tick_tone;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    chip8_tick_tone_if bus_if ();

    chip8_tick_tone #(
        .CLK_HZ  (1200),
        .TICK_HZ (60),
        .TONE_HZ (100)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock, then settle 1 time unit past the edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference 6-high / 6-low square wave, edge k=1 is the first high cycle.
    function automatic logic sq(input int k);
        return (((k - 1) / 6) % 2) == 0;
    endfunction

    task automatic cadence(input string tag);
        int pulses;
        pulses = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            check(tag, {31'd0, bus_if.tick_60}, {31'd0, (c % 20) == 0});
            if (bus_if.tick_60) pulses++;
        end
        check({tag, "_pulses"}, pulses, 5);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset               = 1'b1;
        bus_if.enable       = 1'b0;
        bus_if.sound_active = 1'b0;
        step();
        step();
        check("rst_tick", {31'd0, bus_if.tick_60}, 0);
        check("rst_tone", {31'd0, bus_if.tone_out}, 0);
        check("rst_busy", {31'd0, bus_if.tone_busy}, 0);
`ifdef CHIP8_TICK_COUNT_EN
        check("rst_count", {16'd0, bus_if.tick_count}, 0);
`endif
        reset = 1'b0;

        // Tick cadence: strobes at enabled edges 20,40,...,100
        bus_if.enable = 1'b1;
        cadence("cadence");

        // Pause at count 12 for 7 cycles, resume needs 8 more enabled edges
        for (int i = 1; i <= 12; i++) begin
            step();
            check("pre_pause", {31'd0, bus_if.tick_60}, 0);
        end
        bus_if.enable = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            check("pause", {31'd0, bus_if.tick_60}, 0);
        end
        bus_if.enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("resume", {31'd0, bus_if.tick_60}, {31'd0, i == 8});
        end
        bus_if.enable = 1'b0;

        // Tone start, then drop at phase 3 of a high half
        for (int k = 1; k <= 36; k++) begin
            bus_if.sound_active = (k <= 27);
            step();
            check("stop_hi_tone", {31'd0, bus_if.tone_out}, {31'd0, (k <= 30) ? sq(k) : 1'b0});
            check("stop_hi_busy", {31'd0, bus_if.tone_busy}, {31'd0, k <= 30});
        end

        // Drop during the low half: one DRAIN cycle, then idle, no rise
        for (int k = 1; k <= 20; k++) begin
            bus_if.sound_active = (k <= 8);
            step();
            check("stop_lo_tone", {31'd0, bus_if.tone_out}, {31'd0, k <= 6});
            check("stop_lo_busy", {31'd0, bus_if.tone_busy}, {31'd0, k <= 9});
        end

        // Re-arm while draining a high half: waveform unchanged
        for (int k = 1; k <= 24; k++) begin
            bus_if.sound_active = !(k == 4 || k == 5);
            step();
            check("rearm_tone", {31'd0, bus_if.tone_out}, {31'd0, sq(k)});
            check("rearm_busy", {31'd0, bus_if.tone_busy}, 1);
        end
        bus_if.sound_active = 1'b0;
        for (int i = 0; i < 20 && bus_if.tone_busy; i++) step();
        check("rearm_idle_busy", {31'd0, bus_if.tone_busy}, 0);
        check("rearm_idle_tone", {31'd0, bus_if.tone_out}, 0);

        // Async reset mid-tone while a tick strobe is high
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus_if.enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            bus_if.sound_active = (k >= 16);
            step();
        end
        check("pre_arst_tick", {31'd0, bus_if.tick_60}, 1);
        check("pre_arst_tone", {31'd0, bus_if.tone_out}, 1);
        check("pre_arst_busy", {31'd0, bus_if.tone_busy}, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tick", {31'd0, bus_if.tick_60}, 0);
        check("arst_tone", {31'd0, bus_if.tone_out}, 0);
        check("arst_busy", {31'd0, bus_if.tone_busy}, 0);
`ifdef CHIP8_TICK_COUNT_EN
        check("arst_count", {16'd0, bus_if.tick_count}, 0);
`endif
        step();
        check("arst_hold_tone", {31'd0, bus_if.tone_out}, 0);
        bus_if.sound_active = 1'b0;
        reset = 1'b0;
        cadence("cadence2");
`ifdef CHIP8_TICK_COUNT_EN
        check("count_after_100", {16'd0, bus_if.tick_count}, 5);
`endif
        check("post_tone", {31'd0, bus_if.tone_out}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
